pipelined_rca_adder: RTL

- Parametrised successor to the 4-bit ripple-carry adder. A WIDTH-bit add/subtract unit is split into CHUNK-bit ripple slices, with one slice per pipeline stage.
- The carry is registered between stages. Operands are skewed into the pipeline and sum chunks are de-skewed at the output, so one result emerges per cycle.
- Valid/ready handshake on both sides with full-pipeline stall. Sits in datapaths that need wide adds at a clock rate a single ripple chain cannot meet.

---
 rtl/add_pkg.sv | 11 +
 rtl/rca_chunk.sv | 26 ++
 rtl/pipelined_rca_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared constants and stage-count helper for the pipelined adder
package add_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int stage_count(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational CHUNK-bit ripple-carry slice built from full adders
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co       = w_c[CHUNK];
  // Carry into the top bit lets the last slice form signed overflow locally.
  assign c_msb_in = w_c[CHUNK - 1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// rtl/pipelined_rca_adder.sv - WIDTH-bit add/sub, one CHUNK ripple slice per stage, valid/ready with full stall
module pipelined_rca_adder
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = stage_count(WIDTH, CHUNK);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("pipelined_rca_adder: WIDTH must be a positive multiple of CHUNK");
  end

  logic              w_adv;
  logic [WIDTH-1:0]  w_beff;
  logic              w_c0;
  logic [NSTAGE-1:0] w_vin;
  logic [NSTAGE-1:0] w_cnx;
  logic              w_ovf_nx;
  logic [WIDTH-1:0]  w_opa_nx [NSTAGE];
  logic [WIDTH-1:0]  w_opb_nx [NSTAGE];
  logic [WIDTH-1:0]  w_sum_nx [NSTAGE];

  logic [NSTAGE-1:0] r_v;
  logic [NSTAGE-1:0] r_c;
  logic              r_ovf;
  logic [WIDTH-1:0]  r_opa [NSTAGE];
  logic [WIDTH-1:0]  r_opb [NSTAGE];
  logic [WIDTH-1:0]  r_sum [NSTAGE];

  assign w_adv    = out_ready | ~r_v[NSTAGE-1];
  assign in_ready = w_adv;
  assign w_beff   = (sub == SUB) ? ~b : b;
  assign w_c0     = (sub == ADD) ? cin : 1'b1;

  // Operands shift right one chunk per stage; sum chunks enter at the top and shift down.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [WIDTH-1:0] w_ina;
    logic [WIDTH-1:0] w_inb;
    logic [WIDTH-1:0] w_insum;
    logic             w_ci;
    logic [CHUNK-1:0] w_s;

    if (k == 0) begin : g_first
      assign w_ina    = a;
      assign w_inb    = w_beff;
      assign w_insum  = '0;
      assign w_ci     = w_c0;
      assign w_vin[k] = in_valid;
    end else begin : g_next
      assign w_ina    = r_opa[k-1];
      assign w_inb    = r_opb[k-1];
      assign w_insum  = r_sum[k-1];
      assign w_ci     = r_c[k-1];
      assign w_vin[k] = r_v[k-1];
    end

    if (k == NSTAGE - 1) begin : g_last
      logic w_cmsb;
      rca_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (w_ina[CHUNK-1:0]),
        .b        (w_inb[CHUNK-1:0]),
        .ci       (w_ci),
        .s        (w_s),
        .co       (w_cnx[k]),
        .c_msb_in (w_cmsb)
      );
      assign w_ovf_nx = w_cmsb ^ w_cnx[k];
    end else begin : g_mid
      rca_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (w_ina[CHUNK-1:0]),
        .b        (w_inb[CHUNK-1:0]),
        .ci       (w_ci),
        .s        (w_s),
        .co       (w_cnx[k]),
        .c_msb_in ()
      );
    end

    assign w_opa_nx[k] = w_ina >> CHUNK;
    assign w_opb_nx[k] = w_inb >> CHUNK;
    assign w_sum_nx[k] = (WIDTH'(w_s) << (WIDTH - CHUNK)) | (w_insum >> CHUNK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        r_opa[k] <= '0;
        r_opb[k] <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_adv) begin
      r_v   <= w_vin;
      r_c   <= w_cnx;
      r_ovf <= w_ovf_nx;
      for (int k = 0; k < NSTAGE; k++) begin
        r_opa[k] <= w_opa_nx[k];
        r_opb[k] <= w_opb_nx[k];
        r_sum[k] <= w_sum_nx[k];
      end
    end
  end

  assign out_valid = r_v[NSTAGE-1];
  assign sum       = r_sum[NSTAGE-1];
  assign cout      = r_c[NSTAGE-1];
  assign ovf       = r_ovf;

endmodule
